fixed_to_posit: RTL

Iterative converter from signed two's-complement fixed-point samples to posit⟨N,es⟩ words. It sits at the front of the FFT datapath and produces the posit operands consumed by the posit multiplier and adder stages. It is the encode direction of the posit interface. Conversion is multi-cycle: a start/done handshake, one-bit-per-cycle normalisation, then a single packing and rounding cycle.

---
 rtl/fixed_to_posit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fixed_to_posit.sv
// Iterative signed fixed-point to posit<N,es> encoder.
// One leading-zero shift per cycle in NORM, then a single PACK cycle that builds, rounds and signs the word.
module fixed_to_posit #(
  parameter int N  = 16,
  parameter int es = 3,
  parameter int IW = 16,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] in,
  output logic [N-1:0]  out,
  output logic          done,
  output logic          busy,
  output logic          zero,
  output logic [1:0]    dbg_state
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse that
  // coincides with the new out/zero values; busy spans acceptance through done.

  localparam int KW = $clog2(IW);
  localparam int EW = $clog2(IW) + es + 3;
  localparam int XW = N + es + IW;
  localparam logic signed [EW-1:0] SCALE0  = EW'(IW - 1 - FW);
  localparam logic [EW-1:0]        RUN_MAX = EW'(N - 3);
  localparam logic [N-1:0]         MAXPOS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]         MINPOS  = N'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_PACK = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] m_q, m_d;
  logic [KW-1:0] k_q, k_d;
  logic          s_q, s_d;
  logic          zflag_q, zflag_d;
  logic [N-1:0]  out_q, out_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          zero_q, zero_d;

  logic [IW-1:0]          in_mag;
  logic signed [EW-1:0]   scale;
  logic signed [EW-1:0]   regime_r;
  logic [es-1:0]          exp_bits;
  logic                   rep;
  logic                   term;
  logic [EW-1:0]          run;
  logic [XW-1:0]          y;
  logic [XW-1:0]          cand;
  logic [N-2:0]           body;
  logic                   guard;
  logic                   sticky;
  logic                   round_up;
  logic [N-1:0]           body_r;
  logic                   sat_hi;
  logic [N-1:0]           mag_p;
  logic [N-1:0]           pack_out;

  // Magnitude of the most negative input is 2^(IW-1), which still fits unsigned.
  assign in_mag = in[IW-1] ? (~in + IW'(1)) : in;

  // Regime run is laid in front of {terminator, exponent, fraction} by a fill-shift.
  always_comb begin
    scale    = SCALE0 - $signed({{(EW-KW){1'b0}}, k_q});
    regime_r = scale >>> es;
    exp_bits = scale[es-1:0];
    rep      = ~regime_r[EW-1];
    term     = ~rep;
    run      = rep ? ($unsigned(regime_r) + EW'(1)) : $unsigned(-regime_r);
    y        = {term, exp_bits, m_q[IW-2:0], {N{1'b0}}};
    cand     = rep ? ~((~y) >> run) : (y >> run);
    body     = cand[XW-1 -: N-1];
    guard    = cand[XW-N];
    sticky   = |cand[XW-N-1:0];
    round_up = guard & (sticky | body[0]);
    body_r   = {1'b0, body} + {{(N-1){1'b0}}, round_up};
    sat_hi   = (rep && (run > RUN_MAX)) || body_r[N-1];
    if (sat_hi) begin
      mag_p = MAXPOS;
    end else if (body_r == '0) begin
      mag_p = MINPOS;
    end else begin
      mag_p = body_r;
    end
    pack_out = zflag_q ? '0 : (s_q ? (~mag_p + N'(1)) : mag_p);
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    s_d     = s_q;
    zflag_d = zflag_q;
    out_d   = out_q;
    done_d  = 1'b0;
    busy_d  = 1'b1;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        busy_d = start;
        if (start) begin
          s_d     = in[IW-1];
          m_d     = in_mag;
          k_d     = '0;
          zflag_d = (in == '0);
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (m_q[IW-1] || zflag_q) begin
          state_d = S_PACK;
        end else begin
          m_d = m_q << 1;
          k_d = k_q + KW'(1);
        end
      end
      S_PACK: begin
        out_d   = pack_out;
        zero_d  = zflag_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      k_q     <= '0;
      s_q     <= 1'b0;
      zflag_q <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
      s_q     <= s_d;
      zflag_q <= zflag_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      zero_q  <= zero_d;
    end
  end

  assign out       = out_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule
